// File: rtl/lenet_pkg.sv
// Shared LeNet pipeline definitions.
//   - Feature-map edge sizes for each layer. The controller drives these onto
//     cfg_width/cfg_height of the window buffer.
//   - State encoding for the window buffer FSM.
package lenet_pkg;

    localparam int FM_32 = 32;  // input image
    localparam int FM_28 = 28;  // after C1
    localparam int FM_14 = 14;  // after S2
    localparam int FM_10 = 10;  // after C3
    localparam int FM_5  = 5;   // after S4

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cwb_state_e;

endpackage

// File: rtl/conv_window_buffer_line_ram.sv
// line_ram: one stored image row for the window buffer.
// Combinational read and synchronous write share the same address, so a read
// in the write cycle returns the old contents (read-before-write).
// Ports:
//   clk      clock
//   we_i     write enable
//   addr_i   column address
//   wdata_i  pixel to store
//   rdata_o  pixel currently stored at addr_i
module line_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: K-row line buffer feeding the convolution engine.
// For every accepted raster pixel it emits one K-tall column (oldest row in
// slot 0, current pixel in slot K-1), one cycle later. Rows not yet received
// in the current frame are zero-padded, so old line-memory contents never leak.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_width/cfg_height  image size, sampled on an accepted sof
//   sof, in_valid, in_data  pixel stream (no backpressure)
//   out_valid, out_col    emitted column
//   out_win_valid         a full KxK window ends at this column
//   out_col_idx/out_row_idx  position of the emitted pixel
//   frame_done            pulse with the last pixel of the frame
//   cfg_err               sticky; set by a rejected sof, cleared by an accepted one
module conv_window_buffer
    import lenet_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int CH         = 1,
    parameter  int KERNEL     = 5,
    parameter  int MAX_WIDTH  = 32,
    parameter  int MAX_HEIGHT = 32,
    localparam int WW         = $clog2(MAX_WIDTH + 1),
    localparam int HW         = $clog2(MAX_HEIGHT + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WW-1:0]                cfg_width,
    input  logic [HW-1:0]                cfg_height,
    input  logic                         sof,
    input  logic                         in_valid,
    input  logic [CH*DATA_WIDTH-1:0]     in_data,
    output logic                         out_valid,
    output logic [KERNEL*CH*DATA_WIDTH-1:0] out_col,
    output logic                         out_win_valid,
    output logic [WW-1:0]                out_col_idx,
    output logic [HW-1:0]                out_row_idx,
    output logic                         frame_done,
    output logic                         cfg_err
);

    localparam int PW = CH * DATA_WIDTH;
    localparam int NL = KERNEL - 1;
    localparam int AW = $clog2(MAX_WIDTH);

    localparam logic [WW-1:0] K_W    = WW'(KERNEL);
    localparam logic [WW-1:0] MAXW_W = WW'(MAX_WIDTH);
    localparam logic [HW-1:0] K_H    = HW'(KERNEL);
    localparam logic [HW-1:0] MAXH_H = HW'(MAX_HEIGHT);

    cwb_state_e state_q, state_d;
    logic [WW-1:0] width_q, width_d, col_q, col_d;
    logic [HW-1:0] height_q, height_d, row_q, row_d;
    logic          err_q, err_d;

    logic          out_valid_q, win_q, done_q;
    logic [KERNEL*PW-1:0] col_out_q;
    logic [WW-1:0] col_idx_q;
    logic [HW-1:0] row_idx_q;

    logic          sof_acc, cfg_legal, start, proc, last_col, last_row;
    logic [WW-1:0] cur_col, cur_w;
    logic [HW-1:0] cur_row, cur_h;
    logic [KERNEL*PW-1:0] col_next;
    logic          win_next;

    assign sof_acc   = in_valid & sof;
    assign cfg_legal = (cfg_width >= K_W) && (cfg_width <= MAXW_W) &&
                       (cfg_height >= K_H) && (cfg_height <= MAXH_H);
    assign start     = sof_acc & cfg_legal;
    // A legal sof restarts at (0,0) from either state; plain pixels only count in RUN.
    assign proc      = start | (in_valid & ~sof & (state_q == RUN));

    assign cur_col  = start ? '0 : col_q;
    assign cur_row  = start ? '0 : row_q;
    assign cur_w    = start ? cfg_width : width_q;
    assign cur_h    = start ? cfg_height : height_q;
    assign last_col = (cur_col == cur_w - WW'(1));
    assign last_row = (cur_row == cur_h - HW'(1));

    // Line memory chain: every write shifts the column down one row.
    logic [PW-1:0] rd [NL];
    logic [PW-1:0] wd [NL];

    for (genvar j = 0; j < NL; j++) begin : g_line
        if (j == 0) begin : g_head
            assign wd[j] = in_data;
        end else begin : g_tail
            assign wd[j] = rd[j-1];
        end
        line_ram #(
            .DEPTH(MAX_WIDTH),
            .WIDTH(PW),
            .AW   (AW)
        ) u_line (
            .clk    (clk),
            .we_i   (proc),
            .addr_i (cur_col[AW-1:0]),
            .wdata_i(wd[j]),
            .rdata_o(rd[j])
        );
    end

    // Slot k holds row r-(K-1-k); it is padding until that row exists in this frame.
    for (genvar k = 0; k < NL; k++) begin : g_slot
        assign col_next[k*PW +: PW] = (cur_row >= HW'(NL - k)) ? rd[NL-1-k] : '0;
    end
    assign col_next[NL*PW +: PW] = in_data;
    assign win_next = (cur_row >= HW'(NL)) && (cur_col >= WW'(NL));

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        col_d    = col_q;
        row_d    = row_q;
        err_d    = err_q;
        if (sof_acc) begin
            err_d = ~cfg_legal;
            if (cfg_legal) begin
                width_d  = cfg_width;
                height_d = cfg_height;
                state_d  = RUN;
            end else begin
                state_d = IDLE;
            end
        end
        if (proc) begin
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    row_d = cur_row + HW'(1);
                end
            end else begin
                col_d = cur_col + WW'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            win_q       <= 1'b0;
            done_q      <= 1'b0;
            col_out_q   <= '0;
            col_idx_q   <= '0;
            row_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            col_q       <= col_d;
            row_q       <= row_d;
            err_q       <= err_d;
            out_valid_q <= proc;
            done_q      <= proc & last_col & last_row;
            if (proc) begin
                win_q     <= win_next;
                col_out_q <= col_next;
                col_idx_q <= cur_col;
                row_idx_q <= cur_row;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_col       = col_out_q;
    assign out_win_valid = win_q;
    assign out_col_idx   = col_idx_q;
    assign out_row_idx   = row_idx_q;
    assign frame_done    = done_q;
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer. Expected columns come from a frame image kept
// as a plain 2-D array: slot k of pixel (r,c) is img[r-(K-1-k)][c] of the
// current frame, or zero if that row index is negative.
// Handshake: a pixel is presented by holding in_valid (and sof for the first
// pixel) high for one clock; the DUT never stalls, and out_valid marks the
// single cycle in which the column for that pixel is on the outputs.
module tb_conv_window_buffer;
    import lenet_pkg::*;

    localparam int DW = 8;
    localparam int CH = 1;
    localparam int K  = 5;
    localparam int MW = 32;
    localparam int MH = 32;
    localparam int WW = $clog2(MW + 1);
    localparam int HW = $clog2(MH + 1);
    localparam int PW = DW * CH;
    localparam int CW = K * PW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WW-1:0] cfg_width;
    logic [HW-1:0] cfg_height;
    logic          sof, in_valid;
    logic [PW-1:0] in_data;
    logic          out_valid, out_win_valid, frame_done, cfg_err;
    logic [CW-1:0] out_col;
    logic [WW-1:0] out_col_idx;
    logic [HW-1:0] out_row_idx;

    conv_window_buffer #(
        .DATA_WIDTH(DW), .CH(CH), .KERNEL(K), .MAX_WIDTH(MW), .MAX_HEIGHT(MH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .sof          (sof),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_col      (out_col),
        .out_win_valid(out_win_valid),
        .out_col_idx  (out_col_idx),
        .out_row_idx  (out_row_idx),
        .frame_done   (frame_done),
        .cfg_err      (cfg_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic          v;
        logic [CW-1:0] col;
        logic          win;
        logic [WW-1:0] ci;
        logic [HW-1:0] ri;
        logic          done;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    logic [CW-1:0] seq_q[$];

    int checks   = 0;
    int failures = 0;
    int phase    = 0;
    int n_valid  = 0;
    int n_done   = 0;

    // Reference model state
    bit  m_run = 0;
    bit  m_err = 0;
    int  m_r = 0, m_c = 0, m_w = 0, m_h = 0;
    logic [PW-1:0] img [MH][MW];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare DUT outputs against the oldest expectation.
    task automatic check_outputs();
        exp_t e;
        check_val("exp_q_level", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check_val("out_valid", 64'(out_valid), 64'(e.v));
        check_val("cfg_err", 64'(cfg_err), 64'(e.err));
        if (e.v) begin
            n_valid++;
            check_val("out_col", 64'(out_col), 64'(e.col));
            check_val("out_win_valid", 64'(out_win_valid), 64'(e.win));
            check_val("out_col_idx", 64'(out_col_idx), 64'(e.ci));
            check_val("out_row_idx", 64'(out_row_idx), 64'(e.ri));
            check_val("frame_done", 64'(frame_done), 64'(e.done));
            if (frame_done) n_done++;
            if (phase == 1) begin
                seq_q.push_back(out_col);
                if (e.ri == 4 && e.ci == 4) begin
                    check_val("col_at_4_4", 64'(out_col), 64'h44_34_24_14_04);
                    check_val("win_at_4_4", 64'(out_win_valid), 64'd1);
                end
                if (e.ri == 1 && e.ci == 2) begin
                    check_val("col_at_1_2", 64'(out_col), 64'h12_02_00_00_00);
                    check_val("win_at_1_2", 64'(out_win_valid), 64'd0);
                end
            end
            if (phase == 2 && seq_q.size() > 0)
                check_val("gap_seq", 64'(out_col), 64'(seq_q.pop_front()));
            if ((phase == 1 || phase == 2) && e.done) begin
                check_val("done_px", 64'(out_col[CW-1 -: PW]), 64'h55);
                check_val("done_idx", {out_row_idx, out_col_idx}, {HW'(5), WW'(5)});
            end
            if (phase == 3 && e.ri == 0)
                check_val("pad_row0", 64'(out_col[4*PW-1:0]), 64'd0);
        end else begin
            check_val("frame_done_idle", 64'(frame_done), 64'd0);
        end
    endtask

    // Reference model: one input cycle in, one expected output cycle out.
    task automatic model(input logic v, input logic s, input logic [PW-1:0] d,
                         input int cw, input int chh);
        exp_t e;
        bit   take;
        e    = '0;
        take = 0;
        if (v) begin
            if (s) begin
                if (cw >= K && cw <= MW && chh >= K && chh <= MH) begin
                    m_err = 0; m_run = 1; m_w = cw; m_h = chh; m_r = 0; m_c = 0;
                    take  = 1;
                end else begin
                    m_err = 1; m_run = 0;
                end
            end else begin
                take = m_run;
            end
        end
        if (take) begin
            img[m_r][m_c] = d;
            e.v = 1;
            for (int k = 0; k < K; k++) begin
                int rr;
                rr = m_r - (K - 1 - k);
                e.col[k*PW +: PW] = (rr >= 0) ? img[rr][m_c] : '0;
            end
            e.win = (m_r >= K - 1) && (m_c >= K - 1);
            e.ci  = WW'(m_c);
            e.ri  = HW'(m_r);
            if (m_c == m_w - 1) begin
                m_c = 0;
                if (m_r == m_h - 1) begin
                    e.done = 1;
                    m_run  = 0;
                    m_r    = 0;
                end else begin
                    m_r++;
                end
            end else begin
                m_c++;
            end
        end
        e.err = m_err;
        exp_q.push_back(e);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic s, input logic [PW-1:0] d,
                        input int cw, input int chh);
        @(negedge clk);
        check_outputs();
        in_valid   = v;
        sof        = s;
        in_data    = d;
        cfg_width  = WW'(cw);
        cfg_height = HW'(chh);
        model(v, s, d, cw, chh);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, PW'($urandom), $urandom_range(0, 40), $urandom_range(0, 40));
    endtask

    // Send up to n_px pixels of a w x h frame (n_px < 0: whole frame).
    task automatic send_frame(input int w, input int h, input int gap_pct,
                              input bit pattern, input int n_px);
        int sent;
        sent = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n_px >= 0 && sent >= n_px) return;
                while ($urandom_range(0, 99) < gap_pct) idle(1);
                step(1'b1, (r == 0 && c == 0), pattern ? PW'(r * 16 + c) : PW'($urandom), w, h);
                sent++;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_col"}, 64'(out_col), 64'd0);
        check_val({tag, "_win"}, 64'(out_win_valid), 64'd0);
        check_val({tag, "_cidx"}, 64'(out_col_idx), 64'd0);
        check_val({tag, "_ridx"}, 64'(out_row_idx), 64'd0);
        check_val({tag, "_done"}, 64'(frame_done), 64'd0);
        check_val({tag, "_err"}, 64'(cfg_err), 64'd0);
    endtask

    task automatic reset_mid_frame();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sof      = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_run = 0;
        m_err = 0;
        exp_q.delete();
        exp_q.push_back('0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- sequence ----------------
    initial begin
        int sizes[5];
        sizes = '{FM_32, FM_28, FM_14, FM_10, FM_5};
        rst_n = 1'b0; in_valid = 1'b0; sof = 1'b0; in_data = '0;
        cfg_width = '0; cfg_height = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        exp_q.push_back('0);

        // Continuous 6x6 pattern frame
        phase = 1; n_valid = 0; n_done = 0;
        send_frame(6, 6, 0, 1'b1, -1);
        idle(2);
        check_val("nogap_pulses", 64'(n_valid), 64'd36);

        // Same frame with ~50% gaps
        phase = 2; n_valid = 0; n_done = 0;
        send_frame(6, 6, 50, 1'b1, -1);
        idle(2);
        check_val("gap_pulses", 64'(n_valid), 64'd36);
        check_val("gap_done_cnt", 64'(n_done), 64'd1);

        // Wide frame then narrow frame: no stale rows
        phase = 0;
        send_frame(FM_28, 6, 10, 1'b0, -1);
        phase = 3;
        send_frame(FM_10, 6, 10, 1'b0, -1);
        idle(2);

        // Abort at (3,2): no frame_done for the aborted frame
        phase = 4; n_done = 0;
        send_frame(6, 6, 0, 1'b1, 3 * 6 + 2);
        send_frame(6, 6, 20, 1'b0, -1);
        idle(2);
        check_val("abort_done_cnt", 64'(n_done), 64'd1);

        // Illegal configurations, then a legal frame clears cfg_err
        phase = 5; n_valid = 0;
        step(1'b1, 1'b1, 8'hAA, 4, 6);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, PW'($urandom), 6, 6);
        step(1'b1, 1'b1, 8'hBB, 33, 6);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, PW'($urandom), 6, 6);
        idle(1);
        check_val("illegal_pulses", 64'(n_valid), 64'd0);
        send_frame(FM_5, FM_5, 0, 1'b0, -1);
        idle(2);

        // Reset in the middle of a frame
        phase = 6;
        send_frame(6, 6, 0, 1'b1, 15);
        reset_mid_frame();
        n_valid = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, PW'($urandom), 6, 6);
        idle(1);
        check_val("post_rst_pulses", 64'(n_valid), 64'd0);

        // Random frames, random gaps, occasional illegal sof and aborts
        phase = 7;
        for (int f = 0; f < 8; f++) begin
            int w, h;
            w = sizes[$urandom_range(0, 4)];
            h = $urandom_range(K, 10);
            if ($urandom_range(0, 3) == 0)
                step(1'b1, 1'b1, PW'($urandom), $urandom_range(0, K - 1), h);
            if ($urandom_range(0, 3) == 0)
                send_frame(w, h, 30, 1'b0, $urandom_range(1, w * h - 1));
            send_frame(w, h, $urandom_range(0, 60), 1'b0, -1);
            idle($urandom_range(0, 3));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
